// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared size encodings, FSM states and alignment rule
package mem_access_unit_pkg;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RMW_WAIT = 3'd2,
    WRITE    = 3'd3,
    FINISH   = 3'd4
  } state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return size == 2'b11 || (size == SIZE_WORD && lsb != 2'b00) || (size == SIZE_HALF && lsb[0]);
  endfunction
endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// lane_merge: little-endian byte/half extract-and-extend for loads and lane merge for stores
module lane_merge
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[8*offset +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    load_data = size == SIZE_BYTE ? {{24{sign_ext & b[7]}}, b} :
                size == SIZE_HALF ? {{16{sign_ext & h[15]}}, h} : word;
    merged = word;
    if (size == SIZE_BYTE) merged[8*offset +: 8] = wdata[7:0];
    else if (size == SIZE_HALF) merged[16*offset[1] +: 16] = wdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store responder driving a word-addressed synchronous memory
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Done,
  output logic        Busy,
  output logic        Err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);
  state_t      state, next;
  logic [3:0]  cnt;
  logic [1:0]  size, off;
  logic        sign_ext, err, req, bad, accept, waiting;
  logic [15:0] wdata;
  logic [31:0] load_data, merged;
  assign req = MemRead | MemWrite;
  assign bad = misaligned(Size, Addr[1:0]);
  assign accept = state == IDLE && req;
  assign waiting = state == RD_WAIT || state == RMW_WAIT;
  lane_merge u_lane (
    .word(mem_dout),
    .size(size),
    .offset(off),
    .sign_ext(sign_ext),
    .wdata(wdata),
    .load_data(load_data),
    .merged(merged)
  );
  always_comb begin
    next = state;
    Done = state == FINISH;
    Busy = state != IDLE;
    mem_wr = state == WRITE;
    Err = Done & err;
    case (state)
      IDLE:     if (req) next = bad ? FINISH : MemRead ? RD_WAIT : Size == SIZE_WORD ? WRITE : RMW_WAIT;
      RD_WAIT:  if (cnt == 4'd0) next = FINISH;
      RMW_WAIT: if (cnt == 4'd0) next = WRITE;
      WRITE:    next = FINISH;
      default:  next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      RData <= '0;
      mem_addr <= '0;
      mem_din <= '0;
      size <= SIZE_WORD;
      off <= '0;
      sign_ext <= 1'b0;
      wdata <= '0;
      err <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        mem_addr <= {Addr[31:2], 2'b00};
        off <= Addr[1:0];
        size <= Size;
        sign_ext <= SignExt;
        wdata <= WData[15:0];
        err <= bad;
        cnt <= 4'(READ_LATENCY);
      end else if (waiting && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (accept && next == WRITE) mem_din <= WData;
      if (state == RD_WAIT && cnt == 4'd0) RData <= load_data;
      if (state == RMW_WAIT && cnt == 4'd0) mem_din <= merged;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: runs L=1 and L=4 instances side by side against a spec-level reference model
module tb_mem_access_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0, SignExt = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Addr = '0, WData = '0;
  logic [31:0] RData[2], mem_addr[2], mem_din[2], mem_dout[2];
  logic        Done[2], Busy[2], Err[2], mem_wr[2];
  logic [31:0] mem[2][64];
  logic [31:0] pipe[2][4];
  logic        poke = 1'b0;
  logic [5:0]  poke_a = '0;
  logic [31:0] poke_d = '0;
  int          wr_cnt[2];
  logic [31:0] last_din[2], last_wa[2];
  int          n_assert = 0, n_fail = 0;
  logic [31:0] exp_rdata = '0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_unit #(.READ_LATENCY(g == 0 ? 1 : 4)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
      .SignExt(SignExt), .Addr(Addr), .WData(WData), .RData(RData[g]), .Done(Done[g]),
      .Busy(Busy[g]), .Err(Err[g]), .mem_addr(mem_addr[g]), .mem_wr(mem_wr[g]),
      .mem_din(mem_din[g]), .mem_dout(mem_dout[g])
    );
  end
  assign mem_dout[0] = pipe[0][0];
  assign mem_dout[1] = pipe[1][3];
  // Synchronous memory: read data moves down a pipe so pipe[g][L-1] is valid L edges after the address.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (poke) mem[g][poke_a] <= poke_d;
      else if (mem_wr[g]) mem[g][mem_addr[g][7:2]] <= mem_din[g];
      pipe[g][0] <= mem[g][mem_addr[g][7:2]];
      for (int i = 1; i < 4; i++) pipe[g][i] <= pipe[g][i-1];
      if (mem_wr[g]) begin
        wr_cnt[g] <= wr_cnt[g] + 1;
        last_din[g] <= mem_din[g];
        last_wa[g] <= mem_addr[g];
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic setw(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    poke = 1'b1;
    poke_a = a[7:2];
    poke_d = d;
    @(negedge clk);
    poke = 1'b0;
  endtask
  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic se,
                    input logic [31:0] a, input logic [31:0] wd, input logic hold);
    logic [31:0] w, v, nw, lane;
    logic        bad, wstore;
    int          sh, lat;
    int          exp_off[2], seen[2], wc0[2];
    logic [31:0] got_rd[2];
    logic        got_err[2];
    w = mem[0][a[7:2]];
    sh = 8 * int'(a[1:0]);
    lane = sz == 2'd2 ? 32'hFF : 32'hFFFF;
    bad = sz == 2'd3 || (sz == 2'd0 && a[1:0] != 2'd0) || (sz == 2'd1 && a[0]);
    wstore = !rd && wr && !bad;
    if (rd && !bad) begin
      v = sz == 2'd0 ? w : (w >> sh) & lane;
      if (se && sz == 2'd2 && v >= 32'd128) v += 32'hFFFFFF00;
      if (se && sz == 2'd1 && v >= 32'd32768) v += 32'hFFFF0000;
      exp_rdata = v;
    end
    nw = sz == 2'd0 ? wd : (w & ~(lane << sh)) | ((wd & lane) << sh);
    for (int g = 0; g < 2; g++) begin
      lat = g == 0 ? 1 : 4;
      exp_off[g] = bad ? 0 : rd ? lat + 1 : sz == 2'd0 ? 1 : lat + 2;
      seen[g] = -1;
      wc0[g] = wr_cnt[g];
      got_rd[g] = 'x;
      got_err[g] = 1'bx;
    end
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Size = sz; SignExt = se; Addr = a; WData = wd;
    @(posedge clk);
    for (int k = 0; k < 40 && (seen[0] < 0 || seen[1] < 0); k++) begin
      @(negedge clk);
      if (k == 0)
        for (int g = 0; g < 2; g++) begin
          chk("busy_after_accept", 32'(Busy[g]), 32'd1);
          chk("mem_addr", mem_addr[g], {a[31:2], 2'b00});
        end
      if (!hold || Done[0] || Done[1]) begin MemRead = 1'b0; MemWrite = 1'b0; end
      for (int g = 0; g < 2; g++)
        if (Done[g] && seen[g] < 0) begin
          seen[g] = k;
          got_rd[g] = RData[g];
          got_err[g] = Err[g];
        end
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("done_offset", 32'(seen[g]), 32'(exp_off[g]));
      chk("err", 32'(got_err[g]), 32'(bad));
      chk("rdata", got_rd[g], exp_rdata);
      chk("busy_idle", 32'({Busy[g], Done[g]}), 32'd0);
      chk("write_count", 32'(wr_cnt[g] - wc0[g]), 32'(wstore));
      chk("mem_word", mem[g][a[7:2]], wstore ? nw : w);
      if (wstore) begin
        chk("mem_din", last_din[g], nw);
        chk("write_addr", last_wa[g], {a[31:2], 2'b00});
      end
    end
  endtask
  initial begin
    logic [31:0] a;
    logic        rd;
    int          wc0[2];
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      poke = 1'b1;
      poke_a = 6'(i);
      poke_d = $urandom;
    end
    @(negedge clk);
    poke = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("reset_outputs", {Busy[g], Done[g], Err[g], mem_wr[g], 28'd0}, 32'd0);
      chk("reset_rdata", RData[g], 32'd0);
      chk("reset_mem_addr", mem_addr[g], 32'd0);
      chk("reset_mem_din", mem_din[g], 32'd0);
    end
    reset = 1'b0;
    setw(8'h10, 32'hDEADBEEF);
    op(1, 0, 2'd0, 0, 32'h10, 32'h0, 0);
    setw(8'h10, 32'h80FF7F01);
    op(1, 0, 2'd2, 1, 32'h13, 32'h0, 0);
    op(1, 0, 2'd2, 0, 32'h13, 32'h0, 0);
    op(1, 0, 2'd1, 1, 32'h12, 32'h0, 0);
    op(1, 0, 2'd2, 1, 32'h10, 32'h0, 0);
    setw(8'h20, 32'h11223344);
    op(0, 1, 2'd1, 0, 32'h22, 32'h0000ABCD, 0);
    op(0, 1, 2'd0, 0, 32'h06, 32'h12345678, 0);
    op(1, 0, 2'd1, 1, 32'h05, 32'h0, 0);
    op(1, 0, 2'd3, 0, 32'h40, 32'h0, 0);
    op(0, 1, 2'd3, 0, 32'h40, 32'h55, 0);
    op(1, 1, 2'd0, 0, 32'h20, 32'hFFFFFFFF, 0);
    op(1, 0, 2'd2, 1, 32'h21, 32'h0, 1);
    op(0, 1, 2'd0, 0, 32'h30, 32'h12345678, 1);
    op(0, 1, 2'd2, 0, 32'h31, 32'h000000EE, 1);
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'd0;
      rd = 1'($urandom);
      op(rd, !rd || 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom));
    end
    // Abort a byte store while both instances are still waiting on read data.
    setw(8'h44, 32'hCAFEF00D);
    wc0[0] = wr_cnt[0];
    wc0[1] = wr_cnt[1];
    @(negedge clk);
    MemWrite = 1'b1; Size = 2'd2; SignExt = 1'b0; Addr = 32'h45; WData = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    @(negedge clk);
    chk("busy_in_rmw", 32'(Busy[1]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("abort_outputs", {Busy[g], Done[g], Err[g], mem_wr[g], 28'd0}, 32'd0);
      chk("abort_rdata", RData[g], 32'd0);
      chk("abort_mem_addr", mem_addr[g], 32'd0);
      chk("abort_mem_din", mem_din[g], 32'd0);
    end
    exp_rdata = '0;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("abort_mem_word", mem[g][17], 32'hCAFEF00D);
      chk("abort_no_write", 32'(wr_cnt[g] - wc0[g]), 32'd0);
    end
    op(1, 0, 2'd0, 0, 32'h44, 32'h0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
